serial_cmd_decoder: RTL and testbench

Byte-stream frame decoder sitting directly downstream of the UART receiver on the control board. It consumes one received byte per `rx_new_data` strobe, and frames and validates command packets. On a good checksum it replays the buffered payload as a burst of single-cycle register-write strobes to the board's register bank. It drops malformed, oversized or stalled frames and flags them with an error pulse.

---
 rtl/serial_cmd_decoder_pkg.sv | 26 ++
 rtl/serial_cmd_decoder_if.sv | 23 ++
 rtl/serial_cmd_decoder_buf.sv | 24 ++
 rtl/serial_cmd_decoder.sv | 162 ++++++++++++++++
 tb/tb_serial_cmd_decoder.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_cmd_decoder_pkg.sv
// Shared constants, state encoding and width helpers for the serial command decoder.
package serial_cmd_pkg;

  localparam logic [7:0] DEF_SYNC_BYTE    = 8'hA5;
  localparam int         DEF_MAX_LEN      = 8;
  localparam int         DEF_TIMEOUT_CLKS = 2048;

  // Never returns zero so a degenerate size still yields a legal vector width.
  function automatic int clog2Min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_IDX_W    = clog2Min1(DEF_MAX_LEN + 1);
  localparam int DEF_BUF_AW   = clog2Min1(DEF_MAX_LEN);
  localparam int DEF_TMO_W    = clog2Min1(DEF_TIMEOUT_CLKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/serial_cmd_decoder_if.sv
// Byte-in / register-write-out bundle between the UART side and the register bank.
interface serial_cmd_decoder_if;

  logic [7:0] rx_data;
  logic       rx_new_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx_data, rx_new_data,
    input  wr_en, wr_addr, wr_data, frame_ok, frame_err, busy
  );

  modport slave (
    input  rx_data, rx_new_data,
    output wr_en, wr_addr, wr_data, frame_ok, frame_err, busy
  );

endinterface

// File: rtl/serial_cmd_decoder_buf.sv
// Payload register file: synchronous write while receiving, combinational read while draining.
module cmd_payload_buf
  import serial_cmd_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_LEN,
  parameter int AW    = DEF_BUF_AW
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/serial_cmd_decoder.sv
// Frames SYNC/ADDR/LEN/payload/CHK packets, validates the checksum and replays
// the payload as back-to-back register writes; bad or stalled frames pulse frame_err.
module serial_cmd_decoder
  import serial_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
  parameter int         MAX_LEN      = DEF_MAX_LEN,
  parameter int         TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_cmd_decoder_if.slave  bus
);

  localparam int IDX_W  = clog2Min1(MAX_LEN + 1);
  localparam int BUF_AW = clog2Min1(MAX_LEN);
  localparam int TMO_W  = clog2Min1(TIMEOUT_CLKS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

  state_t           r_state;
  logic [7:0]       r_baseAddr;
  logic [IDX_W-1:0] r_len;
  logic [7:0]       r_sum;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_drainIdx;
  logic [TMO_W-1:0] r_tmo;
  logic             r_wrEn;
  logic [7:0]       r_wrAddr;
  logic [7:0]       r_wrData;
  logic             r_frameOk;
  logic             r_frameErr;

  logic       w_rxStb;
  logic [7:0] w_rxByte;
  logic       w_inFrame;
  logic       w_tmoExpired;
  logic       w_lenOk;
  logic [7:0] w_chkSum;
  logic       w_bufWe;
  logic [7:0] w_bufRdata;

  assign w_rxStb      = bus.rx_new_data;
  assign w_rxByte     = bus.rx_data;
  assign w_inFrame    = (r_state == S_ADDR) || (r_state == S_LEN) ||
                        (r_state == S_PAYLOAD) || (r_state == S_CHECK);
  // A byte landing in the expiry cycle still counts, so expiry requires silence.
  assign w_tmoExpired = w_inFrame && !w_rxStb && (r_tmo == TMO_LAST);
  assign w_lenOk      = (w_rxByte != 8'd0) && (w_rxByte <= 8'(MAX_LEN));
  assign w_chkSum     = r_sum + w_rxByte;
  assign w_bufWe      = (r_state == S_PAYLOAD) && w_rxStb;

  cmd_payload_buf #(
    .DEPTH (MAX_LEN),
    .AW    (BUF_AW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_bufWe),
    .i_waddr (r_idx[BUF_AW-1:0]),
    .i_wdata (w_rxByte),
    .i_raddr (r_drainIdx[BUF_AW-1:0]),
    .o_rdata (w_bufRdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_baseAddr <= '0;
      r_len      <= '0;
      r_sum      <= '0;
      r_idx      <= '0;
      r_drainIdx <= '0;
      r_tmo      <= '0;
      r_wrEn     <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData   <= '0;
      r_frameOk  <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_wrEn     <= 1'b0;
      r_frameOk  <= 1'b0;
      r_frameErr <= 1'b0;

      if (w_inFrame && !w_rxStb && !w_tmoExpired) r_tmo <= r_tmo + TMO_W'(1);
      else                                        r_tmo <= '0;

      unique case (r_state)
        S_IDLE: begin
          if (w_rxStb && (w_rxByte == SYNC_BYTE)) r_state <= S_ADDR;
        end
        S_ADDR: begin
          if (w_rxStb) begin
            r_baseAddr <= w_rxByte;
            r_sum      <= w_rxByte;
            r_state    <= S_LEN;
          end
        end
        S_LEN: begin
          if (w_rxStb) begin
            if (w_lenOk) begin
              r_len      <= w_rxByte[IDX_W-1:0];
              r_sum      <= w_chkSum;
              r_idx      <= '0;
              r_drainIdx <= '0;
              r_state    <= S_PAYLOAD;
            end else begin
              r_frameErr <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_rxStb) begin
            r_sum <= w_chkSum;
            r_idx <= r_idx + IDX_W'(1);
            if ((r_idx + IDX_W'(1)) == r_len) r_state <= S_CHECK;
          end
        end
        // The first write issues straight from the checksum cycle so writes start at T+1.
        S_CHECK: begin
          if (w_rxStb) begin
            if (w_chkSum == 8'd0) begin
              r_wrEn     <= 1'b1;
              r_wrAddr   <= r_baseAddr;
              r_wrData   <= w_bufRdata;
              r_frameOk  <= (r_len == IDX_W'(1));
              r_drainIdx <= IDX_W'(1);
              r_state    <= S_DRAIN;
            end else begin
              r_frameErr <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (r_drainIdx != r_len) begin
            r_wrEn     <= 1'b1;
            r_wrAddr   <= r_baseAddr + 8'(r_drainIdx);
            r_wrData   <= w_bufRdata;
            r_frameOk  <= ((r_drainIdx + IDX_W'(1)) == r_len);
            r_drainIdx <= r_drainIdx + IDX_W'(1);
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_tmoExpired) begin
        r_frameErr <= 1'b1;
        r_state    <= S_IDLE;
      end
    end
  end

  assign bus.wr_en     = r_wrEn;
  assign bus.wr_addr   = r_wrAddr;
  assign bus.wr_data   = r_wrData;
  assign bus.frame_ok  = r_frameOk;
  assign bus.frame_err = r_frameErr;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_cmd_decoder.sv
// Self-checking bench: frames are scored against an event list predicted from the frame rules.
module tb_serial_cmd_decoder;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int MAXL = 8;
  localparam int TMO  = 2048;
  localparam int EV_WR = 1, EV_OK = 2, EV_ERR = 3, EV_RISE = 4, EV_FALL = 5;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  serial_cmd_decoder_if bus();

  serial_cmd_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         nCompared = 0;
  int         nMismatched = 0;
  ev_t        obsQ[$];
  ev_t        expQ[$];
  logic [7:0] fBytes[$];
  int         fGaps[$];
  int         fTimes[$];
  logic       prevBusy = 1'b0;
  logic [7:0] expLastAddr = 8'h00;
  logic [7:0] expLastData = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic ev_t mkEv(input int c, input int k, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.cyc = c; e.kind = k; e.a = a; e.d = d;
    return e;
  endfunction

  // Observed events are logged away from the active edge, in a fixed per-cycle order.
  always @(negedge clk) begin
    if (bus.wr_en)              obsQ.push_back(mkEv(cyc, EV_WR, bus.wr_addr, bus.wr_data));
    if (bus.frame_ok)           obsQ.push_back(mkEv(cyc, EV_OK, 8'h00, 8'h00));
    if (bus.frame_err)          obsQ.push_back(mkEv(cyc, EV_ERR, 8'h00, 8'h00));
    if (bus.busy && !prevBusy)  obsQ.push_back(mkEv(cyc, EV_RISE, 8'h00, 8'h00));
    if (!bus.busy && prevBusy)  obsQ.push_back(mkEv(cyc, EV_FALL, 8'h00, 8'h00));
    if (bus.frame_ok || bus.frame_err)
      checkOutput("okErrExclusive", {31'd0, bus.frame_ok & bus.frame_err}, 32'd0);
    prevBusy = bus.busy;
  end

  task automatic driveByte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    bus.rx_data     = b;
    bus.rx_new_data = 1'b1;
    fTimes.push_back(cyc);
    @(posedge clk); #1;
    bus.rx_new_data = 1'b0;
  endtask

  task automatic startFrame();
    fBytes.delete(); fGaps.delete(); fTimes.delete();
  endtask

  task automatic addByte(input logic [7:0] b, input int gap);
    fBytes.push_back(b);
    fGaps.push_back(gap);
  endtask

  task automatic pushErr(input int t);
    expQ.push_back(mkEv(t, EV_ERR, 8'h00, 8'h00));
    expQ.push_back(mkEv(t, EV_FALL, 8'h00, 8'h00));
  endtask

  // Reference model: reads the frame off the byte list and its arrival cycles.
  task automatic computeExpected();
    int n, s, need, sum, tc, len;
    n = fBytes.size();
    s = 0;
    while (s < n && fBytes[s] != SYNC) s++;
    if (s >= n) return;
    expQ.push_back(mkEv(fTimes[s] + 1, EV_RISE, 8'h00, 8'h00));
    need = 3;
    len  = 0;
    for (int k = 1; k < need; k++) begin
      if (s + k >= n || fTimes[s+k] - fTimes[s+k-1] > TMO) begin
        pushErr(fTimes[s+k-1] + TMO + 1);
        return;
      end
      if (k == 2) begin
        len = int'(fBytes[s+2]);
        if (len == 0 || len > MAXL) begin
          pushErr(fTimes[s+2] + 1);
          return;
        end
        need = 4 + len;
      end
    end
    sum = 0;
    for (int k = 1; k < need; k++) sum += int'(fBytes[s+k]);
    tc = fTimes[s+need-1];
    if (sum % 256 != 0) begin
      pushErr(tc + 1);
      return;
    end
    for (int i = 0; i < len; i++) begin
      expQ.push_back(mkEv(tc + 1 + i, EV_WR, 8'(int'(fBytes[s+1]) + i), fBytes[s+3+i]));
      if (i == len - 1) expQ.push_back(mkEv(tc + 1 + i, EV_OK, 8'h00, 8'h00));
    end
    expQ.push_back(mkEv(tc + len + 1, EV_FALL, 8'h00, 8'h00));
    expLastAddr = 8'(int'(fBytes[s+1]) + len - 1);
    expLastData = fBytes[s+2+len];
  endtask

  task automatic compareEvents();
    int m;
    checkOutput("eventCount", obsQ.size(), expQ.size());
    m = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < m; i++) begin
      checkOutput($sformatf("ev%0d_cycle", i), obsQ[i].cyc, expQ[i].cyc);
      checkOutput($sformatf("ev%0d_kindAddrData", i),
                  {8'd0, 8'(obsQ[i].kind), obsQ[i].a, obsQ[i].d},
                  {8'd0, 8'(expQ[i].kind), expQ[i].a, expQ[i].d});
    end
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic applyStimulus();
    int last;
    fTimes.delete();
    for (int i = 0; i < fBytes.size(); i++) driveByte(fBytes[i], fGaps[i]);
    computeExpected();
    last = (expQ.size() > 0) ? expQ[expQ.size()-1].cyc : cyc;
    while (cyc < last + 3) @(posedge clk);
    @(negedge clk); #1;
    compareEvents();
    checkOutput("holdWrAddr", bus.wr_addr, expLastAddr);
    checkOutput("holdWrData", bus.wr_data, expLastData);
  endtask

  task automatic randomFrame();
    logic [7:0] addr, len, chk, b;
    int sum;
    startFrame();
    repeat ($urandom_range(0, 2)) begin
      do b = 8'($urandom_range(0, 255)); while (b == SYNC);
      addByte(b, $urandom_range(1, 10));
    end
    addByte(SYNC, $urandom_range(1, 10));
    addr = 8'($urandom_range(0, 255));
    addByte(addr, $urandom_range(0, 30));
    len = 8'($urandom_range(0, 10));
    addByte(len, $urandom_range(0, 30));
    if (len != 0 && len <= MAXL) begin
      sum = int'(addr) + int'(len);
      for (int i = 0; i < int'(len); i++) begin
        b = 8'($urandom_range(0, 255));
        sum += int'(b);
        addByte(b, $urandom_range(0, 30));
      end
      chk = 8'(256 - (sum % 256));
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      addByte(chk, $urandom_range(0, 30));
    end
    applyStimulus();
  endtask

  task automatic goodFrame1020(input int gap);
    startFrame();
    addByte(SYNC, gap); addByte(8'h10, gap); addByte(8'h02, gap);
    addByte(8'h11, gap); addByte(8'h22, gap); addByte(8'hBB, gap);
    applyStimulus();
  endtask

  initial begin
    logic [7:0] pay[8];
    int sum, tc;

    bus.rx_data     = 8'h00;
    bus.rx_new_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetWrEn",     bus.wr_en,     0);
    checkOutput("resetWrAddr",   bus.wr_addr,   0);
    checkOutput("resetWrData",   bus.wr_data,   0);
    checkOutput("resetFrameOk",  bus.frame_ok,  0);
    checkOutput("resetFrameErr", bus.frame_err, 0);
    checkOutput("resetBusy",     bus.busy,      0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] basic frame, 600-clock byte spacing");
    goodFrame1020(598);

    $display("[TB] address wrap");
    startFrame();
    addByte(SYNC, 3); addByte(8'hFF, 2); addByte(8'h02, 2);
    addByte(8'h01, 4); addByte(8'h02, 1); addByte(8'hFC, 5);
    applyStimulus();

    $display("[TB] bad checksum then recovery");
    startFrame();
    addByte(SYNC, 2); addByte(8'h10, 2); addByte(8'h02, 2);
    addByte(8'h11, 2); addByte(8'h22, 2); addByte(8'h00, 2);
    applyStimulus();
    goodFrame1020(3);

    $display("[TB] zero and oversized length");
    startFrame();
    addByte(SYNC, 2); addByte(8'h10, 2); addByte(8'h00, 2);
    applyStimulus();
    startFrame();
    addByte(SYNC, 2); addByte(8'h10, 2); addByte(8'h09, 2);
    applyStimulus();
    goodFrame1020(1);

    $display("[TB] inter-byte timeout and byte on the expiry cycle");
    startFrame();
    addByte(SYNC, 2); addByte(8'h10, 2);
    applyStimulus();
    startFrame();
    addByte(SYNC, 2); addByte(8'h10, 2); addByte(8'h02, TMO - 2);
    addByte(8'h11, 2); addByte(8'h22, 2); addByte(8'hBB, 2);
    applyStimulus();

    $display("[TB] reset during drain");
    startFrame();
    sum = 8'h40 + 8;
    for (int i = 0; i < 8; i++) begin
      pay[i] = 8'($urandom_range(0, 255));
      sum += int'(pay[i]);
    end
    fBytes = '{SYNC, 8'h40, 8'h08};
    for (int i = 0; i < 8; i++) fBytes.push_back(pay[i]);
    fBytes.push_back(8'(256 - (sum % 256)));
    for (int i = 0; i < fBytes.size(); i++) driveByte(fBytes[i], 1);
    tc = fTimes[fTimes.size()-1];
    expQ.push_back(mkEv(fTimes[0] + 1, EV_RISE, 8'h00, 8'h00));
    for (int i = 0; i < 3; i++) expQ.push_back(mkEv(tc + 1 + i, EV_WR, 8'(8'h40 + i), pay[i]));
    expQ.push_back(mkEv(tc + 4, EV_FALL, 8'h00, 8'h00));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midResetWrEn",     bus.wr_en,     0);
    checkOutput("midResetWrAddr",   bus.wr_addr,   0);
    checkOutput("midResetWrData",   bus.wr_data,   0);
    checkOutput("midResetFrameOk",  bus.frame_ok,  0);
    checkOutput("midResetFrameErr", bus.frame_err, 0);
    checkOutput("midResetBusy",     bus.busy,      0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    driveByte(8'h00, 3);
    driveByte(8'h11, 3);
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    compareEvents();
    expLastAddr = 8'h00;
    expLastData = 8'h00;
    goodFrame1020(2);

    $display("[TB] randomized frames");
    for (int f = 0; f < 40; f++) randomFrame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
